// File: rtl/uart_debug_server_if.sv
// Byte-stream, memory-port, EXEC and EOC signals of the UART debug boot server.
// The slave modport is the server; the master modport is its surrounding environment.
interface uart_debug_server_if #(
  parameter int unsigned AddrWidth = 64
);
  logic                 rx_valid;
  logic [7:0]           rx_data;
  logic                 rx_ready;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 tx_ready;
  logic                 mem_req;
  logic                 mem_we;
  logic [AddrWidth-1:0] mem_addr;
  logic [7:0]           mem_wdata;
  logic                 mem_gnt;
  logic                 mem_rvalid;
  logic [7:0]           mem_rdata;
  logic                 exec_valid;
  logic [AddrWidth-1:0] exec_addr;
  logic                 eoc_req;
  logic [31:0]          eoc_code;
  logic                 eoc_ack;
  logic                 busy;

  modport slave (
    input  rx_valid, rx_data, tx_ready, mem_gnt, mem_rvalid, mem_rdata, eoc_req, eoc_code,
    output rx_ready, tx_valid, tx_data, mem_req, mem_we, mem_addr, mem_wdata,
           exec_valid, exec_addr, eoc_ack, busy
  );

  modport master (
    output rx_valid, rx_data, tx_ready, mem_gnt, mem_rvalid, mem_rdata, eoc_req, eoc_code,
    input  rx_ready, tx_valid, tx_data, mem_req, mem_we, mem_addr, mem_wdata,
           exec_valid, exec_addr, eoc_ack, busy
  );
endinterface

// File: rtl/uart_debug_server.sv
// UART debug boot protocol server: parses ACK/READ/WRITE/EXEC commands from the RX
// byte stream, performs byte-wide memory accesses and reports EOC exit codes over TX.
module uart_debug_server #(
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned TimeoutCycles = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_debug_server_if.slave   bus
);
  localparam logic [7:0] ByteAck  = 8'h06;
  localparam logic [7:0] ByteEot  = 8'h04;
  localparam logic [7:0] CmdRead  = 8'h11;
  localparam logic [7:0] CmdWrite = 8'h12;
  localparam logic [7:0] CmdExec  = 8'h13;
  localparam logic [7:0] CmdEoc   = 8'h14;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR_ADDR, S_HDR_LEN, S_SEND_ACK, S_RD_REQ, S_RD_WAIT, S_RD_SEND,
    S_WR_RECV, S_WR_REQ, S_WR_WAIT, S_SEND_EOT, S_EXEC, S_EOC_SEND
  } state_t;

  typedef enum logic [1:0] {RET_IDLE, RET_EXEC, RET_DATA} ret_t;

  state_t               state;
  ret_t                 ret;
  logic [7:0]           cmd;
  logic [AddrWidth-1:0] addr;
  logic [63:0]          len;
  logic [63:0]          hdr_sr;
  logic [63:0]          hdr_next;
  logic [2:0]           byte_cnt;
  logic [31:0]          eoc_sr;
  logic [31:0]          idle_cnt;
  logic                 rx_ready;
  logic                 rx_fire;
  logic                 tx_fire;
  logic                 cnt_state;
  logic                 timed_out;

  logic                 tx_valid_q;
  logic [7:0]           tx_data_q;
  logic                 mem_req_q;
  logic                 mem_we_q;
  logic [AddrWidth-1:0] mem_addr_q;
  logic [7:0]           mem_wdata_q;
  logic                 exec_valid_q;
  logic [AddrWidth-1:0] exec_addr_q;
  logic                 eoc_ack_q;

  // A pending EOC request blocks RX in IDLE so it wins over a simultaneous command byte.
  assign cnt_state = (state == S_HDR_ADDR) || (state == S_HDR_LEN) || (state == S_WR_RECV);
  assign rx_ready  = !rst_n && (((state == S_IDLE) && !bus.eoc_req) || cnt_state);
  assign rx_fire   = bus.rx_valid && rx_ready;
  assign tx_fire   = tx_valid_q && bus.tx_ready;
  assign timed_out = (TimeoutCycles != 0) && cnt_state && !rx_fire &&
                     (idle_cnt == 32'(TimeoutCycles - 1));
  // Little-endian fields: each new byte enters at the top, so after 8 bytes byte 0 is at [7:0].
  assign hdr_next  = {bus.rx_data, hdr_sr[63:8]};

  assign bus.rx_ready   = rx_ready;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.exec_valid = exec_valid_q;
  assign bus.exec_addr  = exec_addr_q;
  assign bus.eoc_ack    = eoc_ack_q;
  assign bus.busy       = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state        <= S_IDLE;
      ret          <= RET_IDLE;
      cmd          <= '0;
      addr         <= '0;
      len          <= '0;
      hdr_sr       <= '0;
      byte_cnt     <= '0;
      eoc_sr       <= '0;
      idle_cnt     <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      exec_valid_q <= 1'b0;
      exec_addr_q  <= '0;
      eoc_ack_q    <= 1'b0;
    end else begin
      exec_valid_q <= 1'b0;
      eoc_ack_q    <= 1'b0;

      if (!cnt_state || rx_fire) idle_cnt <= '0;
      else if (TimeoutCycles != 0) idle_cnt <= idle_cnt + 32'd1;

      case (state)
        S_IDLE: begin
          if (bus.eoc_req) begin
            state      <= S_EOC_SEND;
            eoc_sr     <= bus.eoc_code;
            byte_cnt   <= '0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= CmdEoc;
          end else if (rx_fire) begin
            case (bus.rx_data)
              ByteAck: begin
                state      <= S_SEND_ACK;
                ret        <= RET_IDLE;
                tx_valid_q <= 1'b1;
                tx_data_q  <= ByteAck;
              end
              CmdRead, CmdWrite, CmdExec: begin
                state    <= S_HDR_ADDR;
                cmd      <= bus.rx_data;
                byte_cnt <= '0;
              end
              default: ;
            endcase
          end
        end

        S_HDR_ADDR: begin
          if (rx_fire) begin
            hdr_sr   <= hdr_next;
            byte_cnt <= byte_cnt + 3'd1;
            if (byte_cnt == 3'd7) begin
              addr <= hdr_next[AddrWidth-1:0];
              if (cmd == CmdExec) begin
                state      <= S_SEND_ACK;
                ret        <= RET_EXEC;
                tx_valid_q <= 1'b1;
                tx_data_q  <= ByteAck;
              end else begin
                state <= S_HDR_LEN;
              end
            end
          end else if (timed_out) begin
            state <= S_IDLE;
          end
        end

        S_HDR_LEN: begin
          if (rx_fire) begin
            hdr_sr   <= hdr_next;
            byte_cnt <= byte_cnt + 3'd1;
            if (byte_cnt == 3'd7) begin
              len        <= hdr_next;
              state      <= S_SEND_ACK;
              ret        <= RET_DATA;
              tx_valid_q <= 1'b1;
              tx_data_q  <= ByteAck;
            end
          end else if (timed_out) begin
            state <= S_IDLE;
          end
        end

        S_SEND_ACK: begin
          if (tx_fire) begin
            case (ret)
              RET_EXEC: begin
                state      <= S_EXEC;
                tx_valid_q <= 1'b0;
              end
              RET_DATA: begin
                if (len == 64'd0) begin
                  state     <= S_SEND_EOT;
                  tx_data_q <= ByteEot;
                end else if (cmd == CmdRead) begin
                  state      <= S_RD_REQ;
                  tx_valid_q <= 1'b0;
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= addr;
                end else begin
                  state      <= S_WR_RECV;
                  tx_valid_q <= 1'b0;
                end
              end
              default: begin
                state      <= S_IDLE;
                tx_valid_q <= 1'b0;
              end
            endcase
          end
        end

        S_RD_REQ: begin
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            state     <= S_RD_WAIT;
          end
        end

        S_RD_WAIT: begin
          if (bus.mem_rvalid) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= bus.mem_rdata;
            addr       <= addr + AddrWidth'(1);
            len        <= len - 64'd1;
            state      <= S_RD_SEND;
          end
        end

        S_RD_SEND: begin
          if (tx_fire) begin
            if (len == 64'd0) begin
              state     <= S_SEND_EOT;
              tx_data_q <= ByteEot;
            end else begin
              state      <= S_RD_REQ;
              tx_valid_q <= 1'b0;
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= addr;
            end
          end
        end

        S_WR_RECV: begin
          if (rx_fire) begin
            state       <= S_WR_REQ;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr;
            mem_wdata_q <= bus.rx_data;
          end else if (timed_out) begin
            state <= S_IDLE;
          end
        end

        S_WR_REQ: begin
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            state     <= S_WR_WAIT;
          end
        end

        S_WR_WAIT: begin
          if (bus.mem_rvalid) begin
            addr <= addr + AddrWidth'(1);
            len  <= len - 64'd1;
            if (len == 64'd1) begin
              state      <= S_SEND_EOT;
              tx_valid_q <= 1'b1;
              tx_data_q  <= ByteEot;
            end else begin
              state <= S_WR_RECV;
            end
          end
        end

        S_SEND_EOT: begin
          if (tx_fire) begin
            tx_valid_q <= 1'b0;
            state      <= S_IDLE;
          end
        end

        S_EXEC: begin
          exec_addr_q  <= addr;
          exec_valid_q <= 1'b1;
          state        <= S_IDLE;
        end

        // byte_cnt 0..4 walks the EOC byte and four code bytes; 5 is the ack cycle that
        // keeps IDLE from re-seeing eoc_req before the requester has dropped it.
        S_EOC_SEND: begin
          if (byte_cnt == 3'd5) begin
            state <= S_IDLE;
          end else if (tx_fire) begin
            byte_cnt <= byte_cnt + 3'd1;
            if (byte_cnt == 3'd4) begin
              tx_valid_q <= 1'b0;
              eoc_ack_q  <= 1'b1;
            end else begin
              tx_data_q <= eoc_sr[7:0];
              eoc_sr    <= {8'h00, eoc_sr[31:8]};
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_debug_server.sv
// Scoreboard bench for uart_debug_server: stimulus pushes expected TX bytes, memory
// accesses, EXEC addresses and EOC acks; independent monitors pop and compare.
module tb_uart_debug_server;
  localparam int unsigned AW = 64;
  localparam int unsigned TO = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  uart_debug_server_if #(.AddrWidth(AW)) bus ();
  uart_debug_server #(.AddrWidth(AW), .TimeoutCycles(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [7:0]  data;
  } mem_op_t;

  logic [7:0]  exp_tx[$];
  mem_op_t     exp_mem[$];
  logic [63:0] exp_exec[$];
  int          exp_ack = 0;
  logic [7:0]  dev_mem[logic [63:0]];
  logic [7:0]  ref_mem[logic [63:0]];
  logic [7:0]  wr_data[$];
  int errors = 0;
  int checks = 0;
  int tx_ready_pct = 100;
  int gnt_fixed = -1;
  int rv_fixed = -1;
  int gap_max = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dflt(input logic [63:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  // ---------------- environment: TX sink, memory, monitors ----------------
  initial begin
    bus.tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.tx_ready = (int'($urandom_range(0, 99)) < tx_ready_pct);
    end
  end

  logic       tx_held = 1'b0;
  logic [7:0] tx_held_data = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      tx_held = 1'b0;
    end else begin
      if (tx_held)
        chk("tx_hold", 64'({bus.tx_valid, bus.tx_data}), 64'({1'b1, tx_held_data}));
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got %h expected no byte", bus.tx_data);
        end else begin
          chk("tx_byte", 64'(bus.tx_data), 64'(exp_tx.pop_front()));
        end
        tx_held = 1'b0;
      end else begin
        tx_held = bus.tx_valid;
        tx_held_data = bus.tx_data;
      end
      if (bus.exec_valid) begin
        if (exp_exec.size() == 0) begin
          checks++; errors++;
          $display("FAIL exec_unexpected: got addr %h expected no pulse", bus.exec_addr);
        end else begin
          chk("exec_addr", bus.exec_addr, exp_exec.pop_front());
        end
      end
      if (bus.eoc_ack) begin
        checks++;
        if (exp_ack == 0) begin
          errors++;
          $display("FAIL eoc_ack_unexpected: got 1 expected 0");
        end else begin
          exp_ack--;
        end
      end
    end
  end

  initial begin
    logic [63:0] a0;
    logic        w0;
    logic [7:0]  d0;
    int          gd;
    int          rd;
    mem_op_t     op;
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n && bus.mem_req) begin
        a0 = bus.mem_addr; w0 = bus.mem_we; d0 = bus.mem_wdata;
        gd = (gnt_fixed >= 0) ? gnt_fixed : int'($urandom_range(0, 3));
        rd = (rv_fixed >= 0) ? rv_fixed : int'($urandom_range(0, 3));
        repeat (gd) begin @(posedge clk); #1; end
        checks++;
        if (!(bus.mem_req && bus.mem_we === w0 && bus.mem_addr === a0 && bus.mem_wdata === d0)) begin
          errors++;
          $display("FAIL mem_hold: got req=%0b addr=%h expected req=1 addr=%h held", bus.mem_req, bus.mem_addr, a0);
        end
        bus.mem_gnt = 1'b1;
        if (exp_mem.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_unexpected: got we=%0b addr=%h expected no access", w0, a0);
        end else begin
          op = exp_mem.pop_front();
          chk("mem_we", 64'(w0), 64'(op.we));
          chk("mem_addr", a0, op.addr);
          if (op.we) chk("mem_wdata", 64'(d0), 64'(op.data));
        end
        if (w0) dev_mem[a0] = d0;
        @(posedge clk); #1;
        bus.mem_gnt = 1'b0;
        repeat (rd) begin @(posedge clk); #1; end
        chk("mem_single_outstanding", 64'(bus.mem_req), 64'(0));
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = dev_mem.exists(a0) ? dev_mem[a0] : dflt(a0);
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic model_cmd(input logic [7:0] cmd, input logic [63:0] a, input logic [63:0] n);
    logic [63:0] x;
    case (cmd)
      8'h06: exp_tx.push_back(8'h06);
      8'h11: begin
        exp_tx.push_back(8'h06);
        for (int i = 0; i < int'(n); i++) begin
          x = a + 64'(i);
          exp_mem.push_back('{we: 1'b0, addr: x, data: 8'h00});
          exp_tx.push_back(ref_mem.exists(x) ? ref_mem[x] : dflt(x));
        end
        exp_tx.push_back(8'h04);
      end
      8'h12: begin
        exp_tx.push_back(8'h06);
        for (int i = 0; i < int'(n); i++) begin
          x = a + 64'(i);
          exp_mem.push_back('{we: 1'b1, addr: x, data: wr_data[i]});
          ref_mem[x] = wr_data[i];
        end
        exp_tx.push_back(8'h04);
      end
      8'h13: begin
        exp_tx.push_back(8'h06);
        exp_exec.push_back(a);
      end
      default: ;
    endcase
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    bus.rx_valid = 1'b1;
    bus.rx_data = b;
    forever begin
      @(negedge clk);
      if (bus.rx_ready) break;
      n++;
      if (n > 3000) begin
        checks++; errors++;
        $display("FAIL rx_stall: got rx_ready=0 for 3000 cycles expected byte %h taken", b);
        break;
      end
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_mem.size() != 0 || exp_exec.size() != 0 ||
            exp_ack != 0 || bus.busy) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL %s_drain: got busy=%0b tx_left=%0d mem_left=%0d expected idle and drained",
               name, bus.busy, exp_tx.size(), exp_mem.size());
      exp_tx.delete(); exp_mem.delete(); exp_exec.delete(); exp_ack = 0;
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic run_cmd(input string name, input logic [7:0] cmd, input logic [63:0] a,
                         input logic [63:0] n);
    model_cmd(cmd, a, n);
    send_byte(cmd);
    if (cmd == 8'h11 || cmd == 8'h12 || cmd == 8'h13)
      for (int i = 0; i < 8; i++) send_byte(a[8*i +: 8]);
    if (cmd == 8'h11 || cmd == 8'h12)
      for (int i = 0; i < 8; i++) send_byte(n[8*i +: 8]);
    if (cmd == 8'h12)
      for (int i = 0; i < int'(n); i++) send_byte(wr_data[i]);
    wait_done(name);
  endtask

  task automatic do_eoc(input logic [31:0] code);
    int n;
    n = 0;
    exp_tx.push_back(8'h14);
    for (int i = 0; i < 4; i++) exp_tx.push_back(code[8*i +: 8]);
    exp_ack++;
    bus.eoc_code = code;
    bus.eoc_req = 1'b1;
    while (!bus.eoc_ack && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL eoc_ack_timeout: got no eoc_ack expected one pulse");
    end
    bus.eoc_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tx_valid"}, 64'(bus.tx_valid), 64'(0));
    chk({tag, "_mem_req"}, 64'(bus.mem_req), 64'(0));
    chk({tag, "_mem_we"}, 64'(bus.mem_we), 64'(0));
    chk({tag, "_mem_addr"}, bus.mem_addr, 64'(0));
    chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'(0));
    chk({tag, "_exec_valid"}, 64'(bus.exec_valid), 64'(0));
    chk({tag, "_exec_addr"}, bus.exec_addr, 64'(0));
    chk({tag, "_eoc_ack"}, 64'(bus.eoc_ack), 64'(0));
    chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
    chk({tag, "_rx_ready"}, 64'(bus.rx_ready), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic        ack_seen;
    logic [7:0]  cmd;
    logic [63:0] a;
    logic [63:0] n;
    int          cnt;
    bus.rx_valid = 1'b0;
    bus.rx_data = '0;
    bus.eoc_req = 1'b0;
    bus.eoc_code = '0;

    repeat (3) @(posedge clk); #1;
    check_all_zero("reset");
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("idle_rx_ready", 64'(bus.rx_ready), 64'(1));

    run_cmd("ack", 8'h06, 64'h0, 64'h0);

    gnt_fixed = 2;
    wr_data.delete(); wr_data.push_back(8'hAA); wr_data.push_back(8'hBB); wr_data.push_back(8'hCC);
    run_cmd("write3", 8'h12, 64'h8000_1000, 64'd3);
    gnt_fixed = -1;

    dev_mem[64'h2000] = 8'h5A; ref_mem[64'h2000] = 8'h5A;
    dev_mem[64'h2001] = 8'hA5; ref_mem[64'h2001] = 8'hA5;
    rv_fixed = 2;
    run_cmd("read2", 8'h11, 64'h2000, 64'd2);
    rv_fixed = -1;

    run_cmd("exec", 8'h13, 64'h8000_0000, 64'h0);
    wr_data.delete();
    run_cmd("write0", 8'h12, 64'h4000, 64'd0);
    run_cmd("read0", 8'h11, 64'h4000, 64'd0);

    // EOC raised together with an ACK byte under TX backpressure
    tx_ready_pct = 50;
    exp_tx.push_back(8'h14); exp_tx.push_back(8'h01); exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h00); exp_tx.push_back(8'h00); exp_tx.push_back(8'h06);
    exp_ack = 1;
    ack_seen = 1'b0;
    bus.eoc_code = 32'h0000_0001;
    bus.eoc_req = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h06;
    @(negedge clk);
    chk("eoc_priority_rx_ready", 64'(bus.rx_ready), 64'(0));
    fork
      begin
        cnt = 0;
        while (!bus.eoc_ack && cnt < 2000) begin @(negedge clk); cnt++; end
        ack_seen = bus.eoc_ack;
        bus.eoc_req = 1'b0;
      end
      send_byte(8'h06);
    join
    chk("eoc_before_rx", 64'(ack_seen), 64'(1));
    wait_done("eoc_prio");
    tx_ready_pct = 100;

    wr_data.delete(); wr_data.push_back(8'h11); wr_data.push_back(8'h22);
    run_cmd("wrap_write", 8'h12, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    run_cmd("wrap_read", 8'h11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);

    // silence inside the address header
    send_byte(8'h12);
    for (int i = 0; i < 3; i++) send_byte(8'h00);
    cnt = 0;
    while (bus.busy && cnt < 200) begin @(posedge clk); #1; cnt++; end
    chk("timeout_cycles", 64'(cnt), 64'(TO));
    run_cmd("ack_after_timeout", 8'h06, 64'h0, 64'h0);

    // reset while the write response is outstanding
    rv_fixed = 20;
    gnt_fixed = 0;
    exp_tx.push_back(8'h06);
    exp_mem.push_back('{we: 1'b1, addr: 64'h3000, data: 8'h77});
    ref_mem[64'h3000] = 8'h77;
    send_byte(8'h12);
    for (int i = 0; i < 8; i++) send_byte(i == 1 ? 8'h30 : 8'h00);
    for (int i = 0; i < 8; i++) send_byte(i == 0 ? 8'h02 : 8'h00);
    send_byte(8'h77);
    cnt = 0;
    while (exp_mem.size() != 0 && cnt < 200) begin @(posedge clk); #1; cnt++; end
    repeat (3) begin @(posedge clk); #1; end
    chk("wr_wait_busy", 64'(bus.busy), 64'(1));
    rst_n = 1'b1;
    #1;
    check_all_zero("midreset");
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    repeat (30) begin @(posedge clk); #1; end
    rv_fixed = -1;
    gnt_fixed = -1;

    // randomized command mix against the model
    gap_max = 2;
    for (int it = 0; it < 24; it++) begin
      tx_ready_pct = int'($urandom_range(30, 100));
      case ($urandom_range(0, 5))
        0: cmd = 8'h06;
        1: cmd = 8'h11;
        2: cmd = 8'h12;
        3: cmd = 8'h13;
        4: cmd = 8'h14;
        default: cmd = 8'hFF;
      endcase
      a = 64'h1000 + 64'($urandom_range(0, 15));
      n = 64'($urandom_range(0, 4));
      if (cmd == 8'h13) a = {32'($urandom), 32'($urandom)};
      if (cmd == 8'h14) begin
        do_eoc(32'($urandom));
        wait_done("rand_eoc");
      end else begin
        if (cmd == 8'hFF) begin
          cmd = 8'($urandom);
          if (cmd == 8'h06 || cmd == 8'h11 || cmd == 8'h12 || cmd == 8'h13) cmd = 8'hA0;
        end
        wr_data.delete();
        for (int i = 0; i < int'(n); i++) wr_data.push_back(8'($urandom));
        run_cmd("rand", cmd, a, n);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_debug_server.md
Name: uart_debug_server

Overview:
- Hardware server for the UART debug boot protocol driven by the SoC UART VIP: ACK challenge, READ, WRITE, EXEC, EOC.
- Sits between the UART RX/TX byte serialisers and a byte-wide memory request port.
- Parses the command byte stream, performs the memory accesses, and returns ACK/data/EOT bytes.
- Signals EXEC to the boot logic and reports end-of-computation exit codes.

Parameters:
- AddrWidth, 64, width of the memory address and of the EXEC entry address.
- TimeoutCycles, 1000000, maximum clk cycles between two RX bytes inside one command before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- rx_valid  in  1  received byte valid
- rx_data  in  8  received byte
- rx_ready  out  1  byte consumed this cycle
- tx_valid  out  1  byte to transmit valid
- tx_data  out  8  byte to transmit
- tx_ready  in  1  serialiser accepts byte
- mem_req  out  1  memory request
- mem_we  out  1  1=write, 0=read
- mem_addr  out  AddrWidth  byte address
- mem_wdata  out  8  write byte
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read/write response (exactly one per grant)
- mem_rdata  in  8  read byte
- exec_valid  out  1  one-cycle pulse, entry address valid
- exec_addr  out  AddrWidth  entry address, held until next EXEC
- eoc_req  in  1  end-of-computation request, level, held until eoc_ack
- eoc_code  in  32  exit code, stable while eoc_req
- eoc_ack  out  1  one-cycle pulse after last EOC byte accepted
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst_n=1): all outputs 0 and exec_addr=0; FSM in IDLE; counters and address/length registers cleared. Reset asserted mid-command aborts it with no further TX or memory activity.
- Byte constants: ACK=0x06, EOT=0x04, READ=0x11, WRITE=0x12, EXEC=0x13, EOC=0x14.
- Multi-byte fields are little-endian, 8 bytes each; the upper bytes beyond AddrWidth are discarded.
- Handshakes:
  - RX: byte taken when rx_valid&&rx_ready. rx_ready=1 only in IDLE, HDR_ADDR, HDR_LEN and WR_RECV.
  - TX: tx_data stable while tx_valid; transfer on tx_valid&&tx_ready.
  - Memory: mem_req/mem_we/mem_addr/mem_wdata held until mem_gnt; at most one outstanding access; the next request is issued only after mem_rvalid.
- States:
  - IDLE:
    - If eoc_req, go EOC_SEND; this has priority over an RX byte in the same cycle, and rx_ready=0 in that cycle.
    - Else RX byte: ACK -> SEND_ACK(ret IDLE); READ/WRITE/EXEC -> HDR_ADDR (cmd latched); any other byte is dropped.
  - HDR_ADDR: collects 8 bytes into addr. EXEC -> SEND_ACK(ret EXEC); READ/WRITE -> HDR_LEN.
  - HDR_LEN: collects 8 bytes into len (64-bit), then SEND_ACK(ret data phase).
  - SEND_ACK: tx ACK, then go to the return state.
  - READ data phase:
    - If len==0, go SEND_EOT.
    - Else RD_REQ (mem_we=0) -> RD_WAIT (until mem_rvalid, capture mem_rdata) -> RD_SEND (tx byte).
    - After each byte: addr+1, len-1; loop until len==0, then SEND_EOT.
  - WRITE data phase:
    - If len==0, go SEND_EOT.
    - Else WR_RECV (take RX byte) -> WR_REQ (mem_we=1) -> WR_WAIT (until mem_rvalid).
    - After each byte: addr+1, len-1; loop until len==0, then SEND_EOT.
  - SEND_EOT: tx EOT, then IDLE.
  - EXEC: exec_addr<=addr, exec_valid pulse for one cycle, then IDLE.
  - EOC_SEND: tx EOC, then eoc_code bytes [7:0], [15:8], [23:16], [31:24]; eoc_code is sampled on entry. eoc_ack pulses in the cycle after the last byte is accepted; then IDLE.
- Address arithmetic: increments modulo 2^AddrWidth (wrap-around silent).
- Timeout:
  - An idle counter resets on every RX byte and runs only in HDR_ADDR, HDR_LEN and WR_RECV.
  - Reaching TimeoutCycles aborts to IDLE with no TX; memory already written stays written.
- A WRITE with len>0 issues exactly len write accesses; a READ issues exactly len read accesses.
- Latency: ACK tx_valid asserts the cycle after the last header byte is accepted.

Test Plan:
- ACK challenge: RX 0x06 -> TX exactly one 0x06; no mem_req; busy returns 0.
- WRITE: RX 12, addr 0x80001000, len 3, then ACK, then bytes AA BB CC; mem_gnt delayed 2 cycles -> TX 06; writes to 0x80001000/1/2 with AA/BB/CC in order; TX 04.
- READ: memory returns 0x5A, 0xA5 with rvalid 3 cycles after gnt; RX 11, addr 0x2000, len 2 -> TX 06 5A A5 04; two reads at 0x2000, 0x2001.
- EXEC and len=0: RX 13 + addr 0x80000000 -> TX 06, exec_valid single pulse, exec_addr=0x80000000. WRITE with len 0 -> TX 06 04, no mem_req.
- EOC and priority: eoc_req with code 0x00000001 raised in the same cycle as an RX byte -> TX 14 01 00 00 00; eoc_ack pulse; RX byte not consumed until IDLE. TX backpressure (tx_ready toggling) -> tx_data stable.
- Abort: TimeoutCycles=50, RX 12 plus 3 addr bytes then silence -> IDLE after 50 cycles, no TX. Reset asserted during WR_WAIT -> all outputs 0 immediately. Wrap: addr 0xFFFF_FFFF_FFFF_FFFF, len 2 -> second access at address 0.
